// File: rtl/rom_download_router.sv
// Routes MiSTer HPS ioctl download words into cpu ROM / gfx ROM / colour PROM byte writes,
// unpacking each 16-bit word over two cycles and sequencing the CPU reset around the download.
module rom_download_router #(
  parameter logic [26:0] R1_BASE     = 27'h08000,
  parameter logic [26:0] R2_BASE     = 27'h0C000,
  parameter logic [26:0] R2_END      = 27'h0C100,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  output logic [14:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        cpu_rom_wr,
  output logic        gfx_rom_wr,
  output logic        prom_wr,
  output logic        cpu_reset,
  output logic        load_done,
  output logic [16:0] byte_count,
  output logic        overrun
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_HOLD, S_DONE} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

  state_t      r_state;
  logic [25:0] r_addr_hi;
  logic [7:0]  r_data_hi;
  logic        r_dl_prev;
  logic        r_armed;
  logic [7:0]  r_hold_cnt;
  logic        r_wait;
  logic [14:0] r_dl_addr;
  logic [7:0]  r_dl_data;
  logic        r_cpu_wr;
  logic        r_gfx_wr;
  logic        r_prom_wr;
  logic        r_cpu_reset;
  logic        r_load_done;
  logic [16:0] r_byte_count;
  logic        r_overrun;

  logic [26:0] w_word_addr;
  logic [26:0] w_byte_x;
  logic [7:0]  w_byte_d;
  logic [2:0]  w_hit;
  logic [14:0] w_rel [3];
  logic [14:0] w_dl_addr_next;
  logic        w_rise;
  logic        w_busy;
  logic        w_any_wr;

  assign w_word_addr = ioctl_addr & ~27'd1;
  assign w_rise      = ioctl_download & ~r_dl_prev;
  assign w_busy      = (r_state == S_LO) || (r_state == S_HI);
  assign w_any_wr    = r_cpu_wr | r_gfx_wr | r_prom_wr;

  // The byte about to be driven: the low byte of the incoming word while idle,
  // otherwise the high byte of the latched word.
  assign w_byte_x = (r_state == S_IDLE) ? w_word_addr : {r_addr_hi, 1'b1};
  assign w_byte_d = (r_state == S_IDLE) ? ioctl_dout[7:0] : r_data_hi;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_region
      localparam logic [26:0] LO_B = (gi == 0) ? 27'd0 : (gi == 1) ? R1_BASE : R2_BASE;
      localparam logic [26:0] HI_B = (gi == 0) ? R1_BASE : (gi == 1) ? R2_BASE : R2_END;
      if (gi == 0) begin : g_first
        assign w_hit[gi] = (w_byte_x < HI_B);
      end else begin : g_rest
        assign w_hit[gi] = (w_byte_x >= LO_B) && (w_byte_x < HI_B);
      end
      assign w_rel[gi] = 15'(w_byte_x - LO_B);
    end
  endgenerate

  always_comb begin
    w_dl_addr_next = w_byte_x[14:0];
    for (int i = 0; i < 3; i++) begin
      if (w_hit[i]) w_dl_addr_next = w_rel[i];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr_hi    <= '0;
      r_data_hi    <= '0;
      r_dl_prev    <= 1'b0;
      r_armed      <= 1'b1;
      r_hold_cnt   <= '0;
      r_wait       <= 1'b0;
      r_dl_addr    <= '0;
      r_dl_data    <= '0;
      r_cpu_wr     <= 1'b0;
      r_gfx_wr     <= 1'b0;
      r_prom_wr    <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_byte_count <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_wait    <= 1'b0;
      r_cpu_wr  <= 1'b0;
      r_gfx_wr  <= 1'b0;
      r_prom_wr <= 1'b0;

      if (w_rise) begin
        r_byte_count <= '0;
        r_load_done  <= 1'b0;
        r_cpu_reset  <= 1'b1;
        r_armed      <= 1'b1;
      end else if (w_any_wr && (r_byte_count != '1)) begin
        r_byte_count <= r_byte_count + 17'd1;
      end

      if (ioctl_wr && w_busy) r_overrun <= 1'b1;
      else if (w_rise)        r_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (ioctl_download && ioctl_wr) begin
            r_addr_hi <= w_word_addr[26:1];
            r_data_hi <= ioctl_dout[15:8];
            {r_prom_wr, r_gfx_wr, r_cpu_wr} <= w_hit;
            r_dl_addr <= w_dl_addr_next;
            r_dl_data <= w_byte_d;
            r_wait    <= 1'b1;
            r_state   <= S_LO;
          end else if (!ioctl_download && r_armed) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_INIT;
            r_armed    <= 1'b0;
          end
        end
        S_LO: begin
          {r_prom_wr, r_gfx_wr, r_cpu_wr} <= w_hit;
          r_dl_addr <= w_dl_addr_next;
          r_dl_data <= w_byte_d;
          r_wait    <= 1'b1;
          r_state   <= S_HI;
        end
        S_HI: begin
          r_state <= S_IDLE;
        end
        S_HOLD: begin
          // Leaving on count 1 makes the release visible HOLD_CYCLES+1 cycles after idle.
          if (w_rise) begin
            r_state <= S_IDLE;
          end else if (r_hold_cnt <= 8'd1) begin
            r_hold_cnt  <= '0;
            r_cpu_reset <= 1'b0;
            r_load_done <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (w_rise) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ioctl_wait = r_wait;
  assign dl_addr    = r_dl_addr;
  assign dl_data    = r_dl_data;
  assign cpu_rom_wr = r_cpu_wr;
  assign gfx_rom_wr = r_gfx_wr;
  assign prom_wr    = r_prom_wr;
  assign cpu_reset  = r_cpu_reset;
  assign load_done  = r_load_done;
  assign byte_count = r_byte_count;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_rom_download_router.sv
// Self-checking bench for rom_download_router: boundary table, hand-written corner
// sequences, and a randomized download checked against a byte-level reference model.
module tb_rom_download_router;

  localparam int H = 16;
  localparam int K = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic [14:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_rom_wr;
  logic        gfx_rom_wr;
  logic        prom_wr;
  logic        cpu_reset;
  logic        load_done;
  logic [16:0] byte_count;
  logic        overrun;
  logic [2:0]  strb;

  int errors = 0;
  int checks = 0;

  rom_download_router #(.HOLD_CYCLES(H)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .ioctl_wait(ioctl_wait), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_rom_wr(cpu_rom_wr), .gfx_rom_wr(gfx_rom_wr), .prom_wr(prom_wr),
    .cpu_reset(cpu_reset), .load_done(load_done), .byte_count(byte_count),
    .overrun(overrun)
  );

  assign strb = {prom_wr, gfx_rom_wr, cpu_rom_wr};

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] a;
    logic [15:0] d;
    logic [2:0]  s;
    logic [14:0] alo;
    logic [14:0] ahi;
    logic [16:0] cnt;
  } vec_t;

  typedef struct packed {
    logic [2:0]  s;
    logic [14:0] a;
    logic [7:0]  d;
  } byte_t;

  vec_t  tbl [6];
  byte_t expq [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Region rules applied to one absolute byte address.
  function automatic void mdl(input int unsigned x, output logic [2:0] s, output logic [14:0] a);
    if (x < 32'h8000) begin
      s = 3'b001; a = 15'(x);
    end else if (x < 32'hC000) begin
      s = 3'b010; a = 15'(x - 32'h8000);
    end else if (x < 32'hC100) begin
      s = 3'b100; a = 15'(x - 32'hC000);
    end else begin
      s = 3'b000; a = 15'd0;
    end
  endfunction

  task automatic run_word(input logic [26:0] a, input logic [15:0] d, input logic [2:0] s,
                          input logic [14:0] alo, input logic [14:0] ahi, input logic [16:0] cnt);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("lo_strb", strb, s);
    if (s != 3'b000) chk("lo_addr", dl_addr, alo);
    chk("lo_data", dl_data, d[7:0]);
    chk("lo_wait", ioctl_wait, 1);
    tick();
    chk("hi_strb", strb, s);
    if (s != 3'b000) chk("hi_addr", dl_addr, ahi);
    chk("hi_data", dl_data, d[15:8]);
    chk("hi_wait", ioctl_wait, 1);
    tick();
    chk("post_wait", ioctl_wait, 0);
    chk("post_strb", strb, 0);
    chk("post_count", byte_count, cnt);
    $display("word addr=%05h data=%04h strb=%03b count=%0d", a, d, strb, byte_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    k;
    logic  any;
    int    last_acc;
    bit    exp_ovr;
    int    nbytes;

    tbl[0] = '{27'h07FFE, 16'hA1B2, 3'b001, 15'h7FFE, 15'h7FFF, 17'd2};
    tbl[1] = '{27'h08000, 16'hC3D4, 3'b010, 15'h0000, 15'h0001, 17'd4};
    tbl[2] = '{27'h0BFFE, 16'hE5F6, 3'b010, 15'h3FFE, 15'h3FFF, 17'd6};
    tbl[3] = '{27'h0C000, 16'h1728, 3'b100, 15'h0000, 15'h0001, 17'd8};
    tbl[4] = '{27'h0C0FE, 16'h394A, 3'b100, 15'h00FE, 15'h00FF, 17'd10};
    tbl[5] = '{27'h0C100, 16'h5B6C, 3'b000, 15'h0000, 15'h0000, 17'd10};

    // Reset, then idle with download low.
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_dl_addr", dl_addr, 0);
    k = 0; any = 1'b0;
    while (cpu_reset && k < 100) begin
      any = any | (|strb);
      k++;
      tick();
    end
    chk("idle_hold_len", k, H + 1);
    chk("idle_nostrb", any, 0);
    chk("idle_load_done", load_done, 1);
    $display("reset-idle: cpu_reset high %0d cycles, load_done=%0b", k, load_done);

    // Download rise and single word.
    ioctl_download = 1'b1;
    tick();
    chk("rise_cpu_reset", cpu_reset, 1);
    chk("rise_load_done", load_done, 0);
    run_word(27'h00010, 16'hBEEF, 3'b001, 15'h0010, 15'h0011, 17'd2);

    // Fresh download for the boundary table.
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    chk("rerise_count", byte_count, 0);
    for (int i = 0; i < 6; i++)
      run_word(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].alo, tbl[i].ahi, tbl[i].cnt);

    // Busy write is dropped and flags overrun.
    ioctl_addr = 27'h00100; ioctl_dout = 16'h1234; ioctl_wr = 1'b1;
    tick();
    chk("ovr_lo_strb", strb, 3'b001);
    chk("ovr_lo_data", dl_data, 8'h34);
    ioctl_addr = 27'h00200; ioctl_dout = 16'h5678; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("ovr_hi_addr", dl_addr, 15'h0101);
    chk("ovr_hi_data", dl_data, 8'h12);
    tick();
    chk("ovr_flag", overrun, 1);
    chk("ovr_count", byte_count, 12);
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      any = any | (|strb);
      tick();
    end
    chk("ovr_dropped", any, 0);
    chk("ovr_sticky", overrun, 1);
    $display("overrun: overrun=%0b count=%0d", overrun, byte_count);

    // Download falls during the low byte.
    ioctl_addr = 27'h00020; ioctl_dout = 16'hA55A; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    chk("fall_lo_data", dl_data, 8'h5A);
    tick();
    chk("fall_hi_strb", strb, 3'b001);
    chk("fall_hi_addr", dl_addr, 15'h0021);
    chk("fall_hi_data", dl_data, 8'hA5);
    tick();
    chk("fall_count", byte_count, 14);
    k = 0;
    while (!load_done && k < 100) begin
      tick();
      k++;
    end
    chk("fall_hold_len", k, H + 1);
    chk("fall_cpu_reset", cpu_reset, 0);
    $display("fall-midword: load_done after %0d cycles", k);

    // Randomized download against the byte-level model.
    ioctl_download = 1'b1;
    tick();
    chk("rnd_rise_reset", cpu_reset, 1);
    chk("rnd_rise_count", byte_count, 0);
    chk("rnd_rise_ovr", overrun, 0);
    chk("rnd_rise_done", load_done, 0);
    last_acc = -10; exp_ovr = 1'b0; nbytes = 0;
    for (int e = 0; e < K + 4; e++) begin
      logic        do_wr;
      logic [26:0] a;
      logic [15:0] d;
      logic [2:0]  s;
      logic [14:0] ra;
      byte_t       b;
      do_wr = (e < K) && ($urandom_range(0, 2) == 0);
      a = 27'($urandom_range(0, 32'hC1FF));
      d = 16'($urandom);
      ioctl_wr = do_wr; ioctl_addr = a; ioctl_dout = d;
      if (do_wr) begin
        if (e - last_acc >= 3) begin
          last_acc = e;
          mdl(32'(a & ~27'd1), s, ra);
          if (s != 3'b000) begin expq.push_back({s, ra, d[7:0]}); nbytes++; end
          mdl(32'(a | 27'd1), s, ra);
          if (s != 3'b000) begin expq.push_back({s, ra, d[15:8]}); nbytes++; end
          $display("rnd word addr=%05h data=%04h", a, d);
        end else begin
          exp_ovr = 1'b1;
        end
      end
      tick();
      ioctl_wr = 1'b0;
      chk("rnd_wait", ioctl_wait, (last_acc == e) || (last_acc == e - 1));
      if (strb != 3'b000) begin
        if (expq.size() == 0) begin
          chk("rnd_extra_strb", strb, 0);
        end else begin
          b = expq.pop_front();
          chk("rnd_strb", strb, b.s);
          chk("rnd_addr", dl_addr, b.a);
          chk("rnd_data", dl_data, b.d);
        end
      end
    end
    chk("rnd_left", expq.size(), 0);
    chk("rnd_count", byte_count, nbytes);
    chk("rnd_ovr", overrun, exp_ovr);
    ioctl_download = 1'b0;
    k = 0;
    while (!load_done && k < 100) begin
      tick();
      k++;
    end
    chk("rnd_hold_len", k, H + 1);
    $display("random: %0d bytes, overrun=%0b", nbytes, overrun);

    // Reset during the low byte of a word.
    ioctl_download = 1'b1;
    tick();
    ioctl_addr = 27'h08002; ioctl_dout = 16'h0102; ioctl_wr = 1'b1;
    tick();
    ioctl_addr = 27'h00000; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    ioctl_addr = 27'h0C010; ioctl_dout = 16'h0304; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("pre_rst_strb", strb, 3'b100);
    chk("pre_rst_count", byte_count, 2);
    chk("pre_rst_ovr", overrun, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_strb", strb, 0);
    chk("mid_rst_wait", ioctl_wait, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_count", byte_count, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_dl_data", dl_data, 0);
    $display("reset-midword: strb=%03b wait=%0b count=%0d", strb, ioctl_wait, byte_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_download_router.md
# rom_download_router

Sits between the MiSTer HPS download port and the ROM/PROM stores: cpu ROM, gfx ROM and colour PROM. It unpacks each 16-bit ioctl word into two byte writes, decodes each byte's absolute address into one target region and emits a one-cycle write strobe with a region-relative address. It stalls the HPS with `ioctl_wait` while unpacking, holds the CPU in reset during and after a download, and reports load completion and the byte count.

## Interface

Parameters:
- `R1_BASE`, 27'h08000: first byte of gfx ROM region; cpu ROM is [0, R1_BASE)
- `R2_BASE`, 27'h0C000: first byte of colour PROM region; gfx is [R1_BASE, R2_BASE)
- `R2_END`, 27'h0C100: one past last PROM byte; bytes ≥ R2_END are discarded
- `HOLD_CYCLES`, 16: cycles `cpu_reset` stays high after the download completes (1..255)

Ports:
- `clk_sys` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `ioctl_download` in 1: download window active
- `ioctl_addr` in 27: byte address of current word (bit 0 ignored, treated 0)
- `ioctl_dout` in 16: word data; [7:0] = byte at addr, [15:8] = byte at addr+1
- `ioctl_wr` in 1: one-cycle word-valid strobe
- `ioctl_wait` out 1: stall request to HPS
- `dl_addr` out 15: region-relative byte address
- `dl_data` out 8: byte data
- `cpu_rom_wr` out 1: write strobe, cpu ROM
- `gfx_rom_wr` out 1: write strobe, gfx ROM
- `prom_wr` out 1: write strobe, colour PROM
- `cpu_reset` out 1: CPU reset request
- `load_done` out 1: download fully written and hold elapsed
- `byte_count` out 17: bytes strobed into any region this download, saturates at 17'h1FFFF
- `overrun` out 1: sticky; `ioctl_wr` arrived while busy

## Operation

- FSM states: IDLE, LO, HI, HOLD, DONE.
- **IDLE**, `ioctl_download`=1, `ioctl_wr`=1:
  - latch `{ioctl_addr[26:1],1'b0}` and `ioctl_dout`
  - go to LO
- **LO**:
  - drive byte [7:0] at latched address A
  - go to HI
- **HI**:
  - drive byte [15:8] at A+1
  - go to IDLE
- **Region decode**, per byte, on its absolute address X:
  - X < R1_BASE → `cpu_rom_wr`, `dl_addr` = X[14:0]
  - R1_BASE ≤ X < R2_BASE → `gfx_rom_wr`, `dl_addr` = (X−R1_BASE)[14:0]
  - R2_BASE ≤ X < R2_END → `prom_wr`, `dl_addr` = (X−R2_BASE)[14:0]
  - X ≥ R2_END → no strobe; `dl_addr`/`dl_data` still driven, `byte_count` not incremented
- **Strobes**: at most one strobe high per cycle; all strobes 0 outside LO/HI.
- **Download rising edge**:
  - clears `byte_count`, `load_done` and `overrun`
  - sets `cpu_reset`
  - from DONE or HOLD, returns to IDLE
- **Download falling edge**:
  - any pending LO/HI bytes are completed normally
  - once IDLE with download=0 after a download, go to HOLD, counter = HOLD_CYCLES
- **HOLD**:
  - decrements the counter each cycle
  - at 0 → DONE: `cpu_reset`=0, `load_done`=1
- **Busy write**: `ioctl_wr` while in LO/HI is dropped and sets `overrun`. The word being unpacked is not disturbed.
- **Reset** (any state, mid-byte included):
  - state → IDLE with no download history
  - all strobes 0, `ioctl_wait`=0, `cpu_reset`=1, `load_done`=0, `byte_count`=0, `overrun`=0, `dl_addr`=0, `dl_data`=0
  - after reset with download=0, go straight to HOLD, then DONE; a download need not occur first

## Timing

- All outputs registered.
- `ioctl_wr` sampled at edge N:
  - cycle N+1: low-byte strobe, `ioctl_wait`=1
  - cycle N+2: high-byte strobe, `ioctl_wait`=1
  - cycle N+3: `ioctl_wait`=0; earliest accepted next `ioctl_wr` is the one sampled at the edge ending N+3
- Sustained throughput: one word per 3 cycles.
- `cpu_reset` is high in the same cycle the download-rising edge is registered.
- `cpu_reset` falls, and `load_done` rises, exactly HOLD_CYCLES+1 cycles after the state first reaches IDLE with download low.
- `byte_count` updates in the cycle after each counted strobe.

## Test plan

- **Reset then idle**: `reset` 1 cycle, download=0 → `cpu_reset`=1 for HOLD_CYCLES+1 cycles, then `cpu_reset`=0, `load_done`=1, no strobes.
- **Single word**: addr 0x0010, dout 0xBEEF, wr → N+1: `cpu_rom_wr`, `dl_addr`=0x0010, `dl_data`=0xEF; N+2: `dl_addr`=0x0011, `dl_data`=0xBE; `ioctl_wait` high N+1..N+2; `byte_count`=2.
- **Region boundaries**: words at 0x7FFE, 0x8000, 0xBFFE, 0xC000, 0xC0FE, 0xC100:
  - 0x7FFE → `cpu_rom_wr` at `dl_addr` 0x7FFE/0x7FFF
  - 0x8000 → `gfx_rom_wr` at `dl_addr` 0x0000/0x0001
  - 0xBFFE → `gfx_rom_wr` at `dl_addr` 0x3FFE/0x3FFF
  - 0xC000 → `prom_wr` at `dl_addr` 0x0000/0x0001
  - 0xC0FE → `prom_wr` at `dl_addr` 0x00FE/0x00FF
  - 0xC100 → no strobe
  - final `byte_count`=10
- **Overrun**: second `ioctl_wr` one cycle after the first → first word written intact, second dropped, `overrun`=1 until the next download rise.
- **Download ends mid-word**: download falls during LO → HI byte still strobed; HOLD starts afterwards; `load_done` rises after HOLD_CYCLES+1 cycles.
- **Reset mid-word**: `reset` asserted during LO → next cycle all strobes 0, `ioctl_wait`=0, `cpu_reset`=1, `byte_count`=0.
